// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports with write-through
// bypass, one core write port, and a valid/ready load path into EXT_REG.
module regfile_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int EXT_REG  = NUM_REGS - 1
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]   rd_data_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_b,
  input  logic                ext_valid,
  input  logic [DATA_W-1:0]   ext_data,
  output logic                ext_ready,
  output logic [NUM_REGS-1:0] wr_mask,
  input  logic                mask_clr
);

  localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] EXT_ADDR   = ADDR_W'(EXT_REG);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] mask_q;
  logic [NUM_REGS-1:0] mask_d;
  logic                wr_in_range;
  logic                ext_xfer;

  // Handshake: a transfer occurs on a cycle where ext_valid && ext_ready.
  // ext_ready drops only while the core writes EXT_REG (core has priority) and
  // never looks at ext_valid; the source holds valid/data until it sees ready.
  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < NUM_REGS_A);
    ext_ready   = !(wr_en && (wr_addr == EXT_ADDR));
    ext_xfer    = ext_valid && ext_ready;
  end

  always_comb begin
    regs_d = regs_q;
    mask_d = mask_clr ? '0 : mask_q;
    if (ext_xfer) begin
      regs_d[EXT_REG] = ext_data;
      mask_d[EXT_REG] = 1'b1;
    end
    // Setting after clearing makes a coincident write win over mask_clr.
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i))) begin
        regs_d[i] = wr_data;
        mask_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_a == ADDR_W'(i)) rd_data_a = regs_q[i];
      if (rd_addr_b == ADDR_W'(i)) rd_data_b = regs_q[i];
    end
    if (ext_xfer && (rd_addr_a == EXT_ADDR)) rd_data_a = ext_data;
    if (ext_xfer && (rd_addr_b == EXT_ADDR)) rd_data_b = ext_data;
    if (wr_en && wr_in_range && (rd_addr_a == wr_addr)) rd_data_a = wr_data;
    if (wr_en && wr_in_range && (rd_addr_b == wr_addr)) rd_data_b = wr_data;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= DATA_W'(i);
      mask_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      mask_q <= mask_d;
    end
  end

  assign wr_mask = mask_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a 4-register and a 3-register instance share one
// stimulus stream and are compared with a per-instance behavioural model.
module tb_regfile_param;

  logic       clk = 1'b0;
  logic       nReset;
  logic       wr_en, ext_valid, mask_clr;
  logic [1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wr_data, ext_data;
  logic [7:0] rd_a4, rd_b4, rd_a3, rd_b3;
  logic       rdy4, rdy3;
  logic [3:0] mask4;
  logic [2:0] mask3;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 is the 4-register file, index 1 the 3-register file.
  logic [7:0] m  [2][4];
  logic [3:0] mk [2];

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(8), .NUM_REGS(4)) dut4 (
    .clk(clk), .nReset(nReset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_a4), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b4),
    .ext_valid(ext_valid), .ext_data(ext_data), .ext_ready(rdy4),
    .wr_mask(mask4), .mask_clr(mask_clr));

  regfile_param #(.DATA_W(8), .NUM_REGS(3)) dut3 (
    .clk(clk), .nReset(nReset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_a3), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b3),
    .ext_valid(ext_valid), .ext_data(ext_data), .ext_ready(rdy3),
    .wr_mask(mask3), .mask_clr(mask_clr));

  function automatic int nregs(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic logic exp_ready(int k);
    return !(wr_en && int'(wr_addr) == nregs(k) - 1);
  endfunction

  function automatic logic [7:0] exp_rd(int k, logic [1:0] a);
    int n = nregs(k);
    if (int'(a) >= n) return 8'h00;
    if (wr_en && int'(wr_addr) < n && a == wr_addr) return wr_data;
    if (ext_valid && exp_ready(k) && int'(a) == n - 1) return ext_data;
    return m[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m[k][i] = 8'(i);
      mk[k] = '0;
    end
  endtask

  task automatic model_edge();
    if (!nReset) return;
    for (int k = 0; k < 2; k++) begin
      int n = nregs(k);
      if (mask_clr) mk[k] = '0;
      if (ext_valid && exp_ready(k)) begin
        m[k][n-1] = ext_data;
        mk[k][n-1] = 1'b1;
      end
      if (wr_en && int'(wr_addr) < n) begin
        m[k][wr_addr] = wr_data;
        mk[k][wr_addr] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr_a = 0; rd_addr_b = 0;
    ext_valid = 0; ext_data = 0; mask_clr = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    nReset = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    nReset = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nReset = 0;
    idle_inputs();
    model_reset();
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i);
      #1;
      checks++;
      if (rd_a4 !== 8'(i)) begin errors++; $display("FAIL reset_rd_a4[%0d] got %h exp %h", i, rd_a4, 8'(i)); end
    end
    checks++; if (rd_a3 !== 8'h00) begin errors++; $display("FAIL reset_rd_a3_oor got %h exp 00", rd_a3); end
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rdy4); end
    checks++; if (mask4 !== 4'b0000) begin errors++; $display("FAIL reset_mask got %b exp 0000", mask4); end
    @(negedge clk);
    nReset = 1;
  endtask

  task automatic test_write_bypass();
    wr_en = 1; wr_addr = 2; wr_data = 8'hA5; rd_addr_a = 2;
    #1;
    checks++; if (rd_a4 !== 8'hA5) begin errors++; $display("FAIL bypass_same_cycle got %h exp a5", rd_a4); end
    tick();
    wr_en = 0;
    #1;
    checks++; if (rd_a4 !== 8'hA5) begin errors++; $display("FAIL write_stored got %h exp a5", rd_a4); end
    checks++; if (mask4 !== 4'b0100) begin errors++; $display("FAIL write_mask got %b exp 0100", mask4); end
  endtask

  task automatic test_handshake();
    ext_valid = 1; ext_data = 8'h3C; wr_en = 1; wr_addr = 3; wr_data = 8'h11; rd_addr_a = 3;
    #1;
    checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL hs_ready_blocked got %b exp 0", rdy4); end
    checks++; if (rd_a4 !== 8'h11) begin errors++; $display("FAIL hs_core_bypass got %h exp 11", rd_a4); end
    checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL hs_ready3 got %b exp 1", rdy3); end
    tick();
    wr_en = 0;
    #1;
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL hs_ready_free got %b exp 1", rdy4); end
    checks++; if (rd_a4 !== 8'h3C) begin errors++; $display("FAIL hs_ext_bypass got %h exp 3c", rd_a4); end
    tick();
    ext_valid = 0;
    #1;
    checks++; if (rd_a4 !== 8'h3C) begin errors++; $display("FAIL hs_ext_stored got %h exp 3c", rd_a4); end
    checks++; if (mask4[3] !== 1'b1) begin errors++; $display("FAIL hs_mask3 got %b exp 1", mask4[3]); end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    rd_addr_a = 1; rd_addr_b = 3; wr_en = 1; wr_addr = 3; wr_data = 8'hEE;
    #1;
    checks++; if (rd_a3 !== 8'h01) begin errors++; $display("FAIL oor_rd_a got %h exp 01", rd_a3); end
    checks++; if (rd_b3 !== 8'h00) begin errors++; $display("FAIL oor_rd_b got %h exp 00", rd_b3); end
    tick();
    wr_en = 0;
    for (int i = 0; i < 3; i++) begin
      rd_addr_a = 2'(i);
      #1;
      checks++;
      if (rd_a3 !== 8'(i)) begin errors++; $display("FAIL oor_unchanged[%0d] got %h exp %h", i, rd_a3, 8'(i)); end
    end
    checks++; if (mask3 !== 3'b000) begin errors++; $display("FAIL oor_mask got %b exp 000", mask3); end
  endtask

  task automatic test_mask_clr();
    apply_reset();
    wr_en = 1; wr_addr = 1; wr_data = 8'h21;
    tick();
    wr_addr = 2; wr_data = 8'h22;
    tick();
    wr_addr = 0; wr_data = 8'h20; mask_clr = 1;
    #1;
    checks++; if (mask4 !== 4'b0110) begin errors++; $display("FAIL mclr_before got %b exp 0110", mask4); end
    tick();
    wr_en = 0; mask_clr = 0;
    #1;
    checks++; if (mask4 !== 4'b0001) begin errors++; $display("FAIL mclr_race4 got %b exp 0001", mask4); end
    checks++; if (mask3 !== 3'b001) begin errors++; $display("FAIL mclr_race3 got %b exp 001", mask3); end
  endtask

  task automatic test_async_reset();
    wr_en = 1; wr_addr = 1; wr_data = 8'hFF;
    tick();
    wr_en = 0; rd_addr_a = 1;
    #1;
    checks++; if (rd_a4 !== 8'hFF) begin errors++; $display("FAIL ar_pre got %h exp ff", rd_a4); end
    #1;
    nReset = 0;
    model_reset();
    #1;
    checks++; if (rd_a4 !== 8'h01) begin errors++; $display("FAIL ar_contents got %h exp 01", rd_a4); end
    checks++; if (mask4 !== 4'b0000) begin errors++; $display("FAIL ar_mask got %b exp 0000", mask4); end
    wr_en = 1; wr_addr = 0; wr_data = 8'h77;
    tick();
    wr_en = 0; rd_addr_a = 0;
    #1;
    checks++; if (rd_a4 !== 8'h00) begin errors++; $display("FAIL ar_write_discarded got %h exp 00", rd_a4); end
    nReset = 1;
    wr_en = 1; wr_data = 8'h5A;
    tick();
    wr_en = 0;
    #1;
    checks++; if (rd_a4 !== 8'h5A) begin errors++; $display("FAIL ar_first_write got %h exp 5a", rd_a4); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom);
      rd_addr_a = 2'($urandom_range(0, 3));
      rd_addr_b = 2'($urandom_range(0, 3));
      ext_valid = 1'($urandom_range(0, 1));
      ext_data = 8'($urandom);
      mask_clr = ($urandom_range(0, 15) == 0);
      #1;
      checks++; if (rd_a4 !== exp_rd(0, rd_addr_a)) begin errors++; $display("FAIL rnd_rd_a4 c=%0d got %h exp %h", c, rd_a4, exp_rd(0, rd_addr_a)); end
      checks++; if (rd_b4 !== exp_rd(0, rd_addr_b)) begin errors++; $display("FAIL rnd_rd_b4 c=%0d got %h exp %h", c, rd_b4, exp_rd(0, rd_addr_b)); end
      checks++; if (rd_a3 !== exp_rd(1, rd_addr_a)) begin errors++; $display("FAIL rnd_rd_a3 c=%0d got %h exp %h", c, rd_a3, exp_rd(1, rd_addr_a)); end
      checks++; if (rd_b3 !== exp_rd(1, rd_addr_b)) begin errors++; $display("FAIL rnd_rd_b3 c=%0d got %h exp %h", c, rd_b3, exp_rd(1, rd_addr_b)); end
      checks++; if (rdy4 !== exp_ready(0)) begin errors++; $display("FAIL rnd_ready4 c=%0d got %b exp %b", c, rdy4, exp_ready(0)); end
      checks++; if (rdy3 !== exp_ready(1)) begin errors++; $display("FAIL rnd_ready3 c=%0d got %b exp %b", c, rdy3, exp_ready(1)); end
      checks++; if (mask4 !== mk[0]) begin errors++; $display("FAIL rnd_mask4 c=%0d got %b exp %b", c, mask4, mk[0]); end
      checks++; if (mask3 !== mk[1][2:0]) begin errors++; $display("FAIL rnd_mask3 c=%0d got %b exp %b", c, mask3, mk[1][2:0]); end
      tick();
    end
  endtask

  initial begin
    nReset = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_write_bypass();
    test_handshake();
    test_out_of_range();
    test_mask_clr();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file for the 8-bit datapath. It generalises the fixed 4×8 accumulator-fed register set to DATA_W × NUM_REGS with binary addressing and two independent read ports. It adds same-cycle write-through bypass and a valid/ready handshake that loads one designated register from an external (user) source. It sits between the accumulator write-back path and the ALU operand mux; decode (ID) drives the addresses and enables.

## Interface
Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 4, number of registers (2..16, not required to be a power of 2).
- ADDR_W, $clog2(NUM_REGS), address width.
- EXT_REG, NUM_REGS-1, index of the register loadable through the external handshake.

Ports:
- clk  in  1  single clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- wr_en  in  1  core write enable.
- wr_addr  in  ADDR_W  core write address.
- wr_data  in  DATA_W  write data (accumulator output).
- rd_addr_a  in  ADDR_W  read port A address.
- rd_data_a  out  DATA_W  read port A data.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_b  out  DATA_W  read port B data.
- ext_valid  in  1  external data offered for EXT_REG.
- ext_data  in  DATA_W  external data.
- ext_ready  out  1  EXT_REG can accept ext_data this cycle.
- wr_mask  out  NUM_REGS  sticky per-register "written since clear" flags.
- mask_clr  in  1  synchronous clear of wr_mask.

## Operation
- Reset (nReset=0, asynchronous): R[i] = i truncated to DATA_W bits; wr_mask = 0. Read outputs follow the reset contents combinationally.
- Core write: if wr_en and wr_addr < NUM_REGS, R[wr_addr] <= wr_data at the rising edge, and wr_mask[wr_addr] <= 1. Writes to wr_addr >= NUM_REGS are ignored, with no mask change.
- External load: a transfer happens when ext_valid && ext_ready. On a transfer, R[EXT_REG] <= ext_data and wr_mask[EXT_REG] <= 1.
- ext_ready = !(wr_en && wr_addr == EXT_REG). The core write has priority; the external source must hold ext_valid/ext_data until ext_ready=1. ext_ready is independent of ext_valid, so there is no combinational loop.
- Reads are combinational on each port:
  - If wr_en and rd_addr == wr_addr (in range), rd_data = wr_data (bypass).
  - Otherwise, if ext_valid && ext_ready and rd_addr == EXT_REG, rd_data = ext_data (bypass).
  - Otherwise rd_data = R[rd_addr].
  - rd_addr >= NUM_REGS gives rd_data = 0.
- Ports A and B are fully independent; both may address the same register.
- Mask clear: mask_clr=1 sets wr_mask <= 0 at the edge. If mask_clr coincides with a write, the write's bit is set, so set wins over clear.

## Timing
- Write latency is 0 cycles through the bypass (visible on rd_data in the same cycle as wr_en). From the register itself the value is visible from the cycle after the edge.
- The external load follows the same timing as the core write.
- ext_ready is combinational from wr_en/wr_addr only.
- wr_mask updates at the edge following the write/transfer.
- nReset assertion mid-write discards the write. Contents return to reset values immediately, without waiting for clk.
- Released reset: the first write is accepted at the first rising edge with nReset=1.

## Test plan
- Reset check (DATA_W=8, NUM_REGS=4): assert nReset=0 with rd_addr_a=0..3 swept -> rd_data_a = 0,1,2,3; ext_ready=1; wr_mask=4'b0000.
- Write/bypass: wr_en=1, wr_addr=2, wr_data=8'hA5, rd_addr_a=2 -> rd_data_a=8'hA5 in the same cycle. Next cycle with wr_en=0 -> still 8'hA5; wr_mask=4'b0100.
- Handshake conflict: ext_valid=1, ext_data=8'h3C while wr_en=1, wr_addr=3, wr_data=8'h11 -> ext_ready=0, R3=8'h11. Next cycle wr_en=0 -> ext_ready=1, R3=8'h3C after the edge.
- Dual read plus out-of-range: NUM_REGS=3, rd_addr_a=1, rd_addr_b=3, write to addr 3 -> rd_data_a=1, rd_data_b=0, no register change, wr_mask unchanged.
- Mask clear race: mask_clr=1 with a write to R0 in the same cycle, after earlier writes to R1 and R2 -> wr_mask=4'b0001.
- Async reset mid-stream: write R1=8'hFF, then drop nReset between clock edges -> rd_data for R1 = 8'h01 before the next edge; wr_mask=0.
